// File: rtl/booth_r4_seq_mult_pkg.sv
// booth_pkg: shared Booth radix-4 digit type, digit constants and FSM state enum
package booth_pkg;
  typedef logic [2:0] digit_t;
  localparam digit_t BOOTH_ZERO = 3'b000;
  localparam digit_t BOOTH_P1   = 3'b001;
  localparam digit_t BOOTH_P2   = 3'b010;
  localparam digit_t BOOTH_N1   = 3'b101;
  localparam digit_t BOOTH_N2   = 3'b110;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/booth_r4_seq_mult_if.sv
// booth_r4_seq_mult_if: start/operand request and ready/done/product response bundle
interface booth_r4_seq_mult_if #(parameter int WIDTH = 8);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   ready;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
  modport master (output start, multiplicand, multiplier, input ready, done, product);
  modport slave (input start, multiplicand, multiplier, output ready, done, product);
endinterface

// File: rtl/booth_r4_digit.sv
// booth_r4_digit: recodes a 3-bit multiplier window into a {neg, two, one} digit
import booth_pkg::*;
module booth_r4_digit (
  input  logic [2:0] win,
  output digit_t     dig
);
  assign dig = (win == 3'b000 || win == 3'b111) ? BOOTH_ZERO :
               win == 3'b011 ? BOOTH_P2 :
               win == 3'b100 ? BOOTH_N2 :
               win[2] ? BOOTH_N1 : BOOTH_P1;
endmodule

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential signed radix-4 Booth multiplier, one digit per clock (optional BOOTH_EARLY_TERM_EN)
import booth_pkg::*;
module booth_r4_seq_mult #(parameter int WIDTH = 8) (
  input logic               clk,
  input logic               rst_n,
  booth_r4_seq_mult_if.slave bus
);
  localparam int NDIG = WIDTH / 2;
  localparam int CW = $clog2(NDIG);
  localparam int PW = 2 * WIDTH;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d, prod_q, prod_d, pp, ext;
  logic [CW-1:0]    idx_q, idx_d;
  logic             done_q, done_d, last;
  logic [WIDTH:0]   bx, mag;
  logic [2:0]       win;
  digit_t           dig;
  // select the window {B[2i+1], B[2i], B[2i-1]} with B[-1] = 0
  always_comb begin
    bx = {b_q, 1'b0};
    win = '0;
    for (int k = 0; k < NDIG; k++) if (idx_q == CW'(k)) win = bx[2*k +: 3];
  end
  booth_r4_digit u_digit (.win(win), .dig(dig));
  // |digit|*A at WIDTH+1 bits, sign-extended before negation so -2*(-2^(WIDTH-1)) stays exact
  always_comb begin
    mag = dig[1] ? {a_q, 1'b0} : dig[0] ? {a_q[WIDTH-1], a_q} : '0;
    ext = {{(WIDTH-1){mag[WIDTH]}}, mag};
    pp = (dig[2] ? -ext : ext) << (2 * idx_q);
  end
`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH-1:0] rem;
  // finish once every remaining multiplier bit equals the sign, i.e. all later digits are zero
  always_comb begin
    rem = $signed(b_q) >>> (2 * idx_q + 1);
    last = rem == '0 || rem == '1;
  end
`else
  assign last = idx_q == CW'(NDIG - 1);
`endif
  // next-state: accept in IDLE, accumulate one digit per cycle in RUN
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    idx_d = idx_q;
    prod_d = prod_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        a_d = bus.multiplicand;
        b_d = bus.multiplier;
        acc_d = '0;
        idx_d = '0;
        state_d = RUN;
      end
    end else begin
      acc_d = acc_q + pp;
      idx_d = idx_q + 1'b1;
      if (last) begin
        prod_d = acc_q + pp;
        done_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  // state, operand, accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      prod_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      prod_q <= prod_d;
      done_q <= done_d;
    end
  end
  assign bus.ready = state_q == IDLE;
  assign bus.done = done_q;
  assign bus.product = prod_q;
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb_booth_r4_seq_mult: randomized scoreboard bench for booth_r4_seq_mult against signed integer multiply
module tb_booth_r4_seq_mult;
  localparam int W = 8;
  localparam int NDIG = W / 2;
  localparam int PW = 2 * W;
  typedef struct {logic [PW-1:0] prod; int lat; int acc_cyc;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  exp_t e;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pend_lat = -1;
  logic [PW-1:0] held = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  booth_r4_seq_mult_if #(.WIDTH(W)) bus();
  booth_r4_seq_mult #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask
  // digits needed: smallest count whose (2n)-bit signed range holds B
  function automatic int lat_of(input logic signed [W-1:0] b);
    int bi;
    bi = b;
`ifdef BOOTH_EARLY_TERM_EN
    for (int i = 0; i < NDIG; i++) if (bi >= -(1 << (2*i+1)) && bi < (1 << (2*i+1))) return i + 1;
`endif
    return NDIG;
  endfunction
  // monitor: pop expected result on each done, and require product to hold otherwise
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: done=1 with no pending operation, expected done=0");
        end else begin
          e = q.pop_front();
          check("latency", cyc - e.acc_cyc, e.lat);
          held = e.prod;
        end
      end
      check("product", bus.product, held);
    end
  end
  task automatic op(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready) begin
      n++;
      if (n > 40) begin
        fails++;
        $display("FAIL ready_timeout: ready=0 for %0d cycles, expected 1", n);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "ready timeout");
      end
      @(negedge clk);
    end
    if (pend_lat >= 0) check("busy_cycles", n, pend_lat);
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.multiplicand = W'($urandom);
    bus.multiplier = W'($urandom);
    q.push_back('{prod: PW'(longint'(a) * longint'(b)), lat: lat_of(b), acc_cyc: cyc});
    pend_lat = lat_of(b);
  endtask
  task automatic gap(input int k);
    repeat (k) @(negedge clk);
    pend_lat = -1;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", bus.ready, 1);
    check("reset_done", bus.done, 0);
    check("reset_product", bus.product, 0);
    rst_n = 1'b1;
    op(7, 3);
    op(-128, -128);
    op(-128, 127);
    op(-1, 1);
    op(0, -77);
    op(5, 6);
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 3;
    bus.multiplier = -7;
    @(negedge clk);
    bus.start = 1'b0;
    gap(8);
    op(9, 9);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    held = '0;
    pend_lat = -1;
    #1;
    check("abort_product", bus.product, 0);
    check("abort_ready", bus.ready, 1);
    check("abort_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op(9, 9);
    op(5, 1);
    op(-128, -1);
    op(127, -128);
    op(1, -2);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) gap($urandom_range(1, 3));
      op(W'($urandom), W'($urandom));
    end
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    check("drain", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
